rf_op_sequencer: RTL

//  Initiator for the 32x32 register file: accepts one ALU command (op, rs1, rs2, rd) via valid/ready.

---
 rtl/rf_seq_pkg.sv | 26 ++
 rtl/rf_seq_alu.sv | 42 ++++
 rtl/rf_op_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file operation sequencer: widths, opcodes, FSM states.
package rf_seq_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_OP_W   = 3;
    localparam int SHAMT_W    = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EX   = 3'd2,
        ST_WB   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer. Shifts (opcodes 6/7) exist only when RF_SEQ_SHIFT_EN
// is defined; otherwise those opcodes report illegal with a zero result.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic [OP_W-1:0]   op_s,
    input  logic [DATA_W-1:0] a_s,
    input  logic [DATA_W-1:0] b_s,
    output logic [DATA_W-1:0] result_s,
    output logic              illegal_s
);

    logic slt_s;

    assign slt_s = ($signed(a_s) < $signed(b_s));

    // Opcode decode and result selection
    always_comb begin
        result_s  = '0;
        illegal_s = 1'b0;
        case (op_s)
            OP_ADD: result_s = a_s + b_s;
            OP_SUB: result_s = a_s - b_s;
            OP_AND: result_s = a_s & b_s;
            OP_OR:  result_s = a_s | b_s;
            OP_XOR: result_s = a_s ^ b_s;
            OP_SLT: result_s = {{(DATA_W-1){1'b0}}, slt_s};
`ifdef RF_SEQ_SHIFT_EN
            OP_SLL: result_s = a_s << b_s[SHAMT_W-1:0];
            OP_SRL: result_s = a_s >> b_s[SHAMT_W-1:0];
`endif
            default: begin
                result_s  = '0;
                illegal_s = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one ALU command through read, execute and write-back against the register file.
// Optional shift opcodes are enabled by defining RF_SEQ_SHIFT_EN.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [OP_W-1:0]   i_op,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [ADDR_W-1:0] i_rd,
    output logic [ADDR_W-1:0] o_raddr1,
    output logic [ADDR_W-1:0] o_raddr2,
    input  logic [DATA_W-1:0] i_rdata1,
    input  logic [DATA_W-1:0] i_rdata2,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_we,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    state_e              state_r;
    logic [OP_W-1:0]     op_r;
    logic [ADDR_W-1:0]   rd_r;
    logic [DATA_W-1:0]   opa_r;
    logic [DATA_W-1:0]   opb_r;
    logic [DATA_W-1:0]   result_r;
    logic                err_r;
    logic [DATA_W-1:0]   alu_result_s;
    logic                alu_illegal_s;

    rf_seq_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op_s      (op_r),
        .a_s       (opa_r),
        .b_s       (opb_r),
        .result_s  (alu_result_s),
        .illegal_s (alu_illegal_s)
    );

    // Command sequencing FSM with all outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            op_r        <= '0;
            rd_r        <= '0;
            opa_r       <= '0;
            opb_r       <= '0;
            result_r    <= '0;
            err_r       <= 1'b0;
            o_cmd_ready <= 1'b0;
            o_raddr1    <= '0;
            o_raddr2    <= '0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_we        <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_cmd_ready <= 1'b1;
                    if (i_cmd_valid && o_cmd_ready) begin
                        op_r        <= i_op;
                        rd_r        <= i_rd;
                        o_raddr1    <= i_rs1;
                        o_raddr2    <= i_rs2;
                        o_cmd_ready <= 1'b0;
                        state_r     <= ST_RD;
                    end
                end
                // Read data settled at the mid-cycle negedge; capture it now
                ST_RD: begin
                    opa_r    <= i_rdata1;
                    opb_r    <= i_rdata2;
                    o_raddr1 <= '0;
                    o_raddr2 <= '0;
                    state_r  <= ST_EX;
                end
                ST_EX: begin
                    result_r <= alu_result_s;
                    err_r    <= alu_illegal_s;
                    o_we     <= (!alu_illegal_s) && (rd_r != {ADDR_W{1'b0}});
                    o_waddr  <= rd_r;
                    o_wdata  <= alu_result_s;
                    state_r  <= ST_WB;
                end
                ST_WB: begin
                    o_we        <= 1'b0;
                    o_waddr     <= '0;
                    o_wdata     <= '0;
                    o_rsp_valid <= 1'b1;
                    o_rsp_data  <= result_r;
                    o_rsp_err   <= err_r;
                    state_r     <= ST_RSP;
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_data  <= '0;
                        o_rsp_err   <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    o_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
